// File: rtl/sprite_plot_sequencer.sv
// Per-frame sprite sequencer: erases every bird at its previous anchor, then draws
// every live bird at its new anchor, one clipped pixel per cycle into vga_adapter.
module sprite_plot_sequencer #(
   parameter int         NUM_BIRDS   = 4,
   parameter logic [2:0] BIRD_COLOUR = 3'b110,
   parameter logic [2:0] BG_COLOUR   = 3'b000,
   parameter int         X_MAX       = 160,
   parameter int         Y_MAX       = 120
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [8*NUM_BIRDS-1:0] bird_x,
   input  logic [7*NUM_BIRDS-1:0] bird_y,
   input  logic [NUM_BIRDS-1:0]   bird_alive,
   output logic [7:0]             vga_x,
   output logic [6:0]             vga_y,
   output logic [2:0]             vga_colour,
   output logic                   vga_plot,
   output logic                   busy,
   output logic                   done
);
   // state   | meaning
   // S_IDLE  | waiting for frame_tick, outputs quiet
   // S_ERASE | sweeping all birds at old anchors with BG_COLOUR
   // S_DRAW  | sweeping all birds at new anchors with BIRD_COLOUR
   // S_DONE  | one-cycle done pulse, then back to idle
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ERASE = 2'd1;
   localparam logic [1:0] S_DRAW  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int             BW        = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
   localparam logic [BW-1:0]  LAST_BIRD = BW'(NUM_BIRDS - 1);
   localparam logic [3:0]     LAST_PIX  = 4'd12;
   localparam logic [8:0]     X_LIM     = 9'(X_MAX);
   localparam logic [8:0]     Y_LIM     = 9'(Y_MAX);

   logic [1:0]             state;
   logic [BW-1:0]          bird;
   logic [3:0]             pix;
   logic [8*NUM_BIRDS-1:0] new_x, old_x;
   logic [7*NUM_BIRDS-1:0] new_y, old_y;
   logic [NUM_BIRDS-1:0]   new_alive, old_alive;
   logic                   last_slot;

   assign last_slot = (bird == LAST_BIRD) && (pix == LAST_PIX);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         bird      <= '0;
         pix       <= '0;
         new_x     <= '0;
         new_y     <= '0;
         new_alive <= '0;
         old_x     <= '0;
         old_y     <= '0;
         old_alive <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  new_x     <= bird_x;
                  new_y     <= bird_y;
                  new_alive <= bird_alive;
                  bird      <= '0;
                  pix       <= '0;
                  state     <= S_ERASE;
               end
            end
            S_ERASE, S_DRAW: begin
               if (pix == LAST_PIX) begin
                  pix  <= '0;
                  bird <= (bird == LAST_BIRD) ? '0 : bird + 1'b1;
               end else begin
                  pix <= pix + 4'd1;
               end
               if (last_slot) begin
                  if (state == S_ERASE) begin
                     state <= S_DRAW;
                  end else begin
                     // new frame becomes the reference for next frame's erase
                     old_x     <= new_x;
                     old_y     <= new_y;
                     old_alive <= new_alive;
                     state     <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [7:0] ax;
   logic [6:0] ay;
   logic       slot_alive;
   logic [3:0] dx, dy;
   logic [8:0] px, py;
   logic       on_screen;

   always_comb begin
      ax         = new_x[8*bird +: 8];
      ay         = new_y[7*bird +: 7];
      slot_alive = new_alive[bird];
      if (state == S_ERASE) begin
         ax         = old_x[8*bird +: 8];
         ay         = old_y[7*bird +: 7];
         slot_alive = old_alive[bird];
      end
      // duck shape offsets, two's complement in 4 bits
      case (pix)
         4'd0:    begin dx = 4'd0;     dy = 4'd0;     end
         4'd1:    begin dx = 4'd0;     dy = 4'd1;     end
         4'd2:    begin dx = -4'sd1;   dy = 4'd0;     end
         4'd3:    begin dx = -4'sd2;   dy = 4'd0;     end
         4'd4:    begin dx = -4'sd3;   dy = 4'd0;     end
         4'd5:    begin dx = -4'sd4;   dy = 4'd0;     end
         4'd6:    begin dx = -4'sd5;   dy = 4'd0;     end
         4'd7:    begin dx = -4'sd3;   dy = 4'd1;     end
         4'd8:    begin dx = -4'sd3;   dy = -4'sd1;   end
         4'd9:    begin dx = -4'sd4;   dy = 4'd2;     end
         4'd10:   begin dx = -4'sd4;   dy = -4'sd2;   end
         4'd11:   begin dx = -4'sd5;   dy = 4'd3;     end
         4'd12:   begin dx = -4'sd5;   dy = -4'sd3;   end
         default: begin dx = 4'd0;     dy = 4'd0;     end
      endcase
      // bit 8 set means the pixel landed left of / above the screen
      px        = {1'b0, ax} + {{5{dx[3]}}, dx};
      py        = {2'b0, ay} + {{5{dy[3]}}, dy};
      on_screen = !px[8] && (px < X_LIM) && !py[8] && (py < Y_LIM);

      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      if (busy) begin
         vga_x      = px[7:0];
         vga_y      = py[6:0];
         vga_colour = (state == S_ERASE) ? BG_COLOUR : BIRD_COLOUR;
         vga_plot   = slot_alive && on_screen;
      end
   end

   assign busy = (state == S_ERASE) || (state == S_DRAW);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_sprite_plot_sequencer.sv
// Bench for sprite_plot_sequencer: a frame model fills a scoreboard of expected
// per-cycle outputs at each accepted tick; targeted cases add fixed-value checks.
module tb_sprite_plot_sequencer;
   localparam int NB = 4;
   localparam int FRAME = 26 * NB + 1;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic          frame_tick;
   logic [31:0]   bird_x;
   logic [27:0]   bird_y;
   logic [3:0]    bird_alive;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot;
   logic          busy;
   logic          done;

   sprite_plot_sequencer #(.NUM_BIRDS(NB)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
      .bird_x(bird_x), .bird_y(bird_y), .bird_alive(bird_alive),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .done(done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       plot;
      logic       busy;
      logic       done;
   } out_t;

   out_t sb[$];
   out_t obs[1:FRAME];
   int   tests = 0;
   int   fails = 0;

   int   DX[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
   int   DY[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};
   int   m_old_x[NB];
   int   m_old_y[NB];
   logic m_old_alive[NB];

   function automatic out_t current();
      return {vga_x, vga_y, vga_colour, vga_plot, busy, done};
   endfunction

   function automatic int count_plots(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (obs[c].plot) n++;
      return n;
   endfunction

   function automatic int count_done();
      int n = 0;
      for (int c = 1; c <= FRAME; c++) if (obs[c].done) n++;
      return n;
   endfunction

   task automatic push_frame(input logic [31:0] bx, input logic [27:0] by, input logic [3:0] ba);
      out_t e;
      int ax, ay, px, py;
      logic alive;
      for (int ph = 0; ph < 2; ph++) begin
         for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < 13; p++) begin
               if (ph == 0) begin
                  ax = m_old_x[b]; ay = m_old_y[b]; alive = m_old_alive[b];
               end else begin
                  ax = int'(bx[8*b +: 8]); ay = int'(by[7*b +: 7]); alive = ba[b];
               end
               px = ax + DX[p];
               py = ay + DY[p];
               e.x    = 8'(px);
               e.y    = 7'(py);
               e.c    = (ph == 0) ? 3'b000 : 3'b110;
               e.plot = alive && px >= 0 && px < 160 && py >= 0 && py < 120;
               e.busy = 1'b1;
               e.done = 1'b0;
               sb.push_back(e);
            end
         end
      end
      e = '0;
      e.done = 1'b1;
      sb.push_back(e);
      for (int b = 0; b < NB; b++) begin
         m_old_x[b]     = int'(bx[8*b +: 8]);
         m_old_y[b]     = int'(by[7*b +: 7]);
         m_old_alive[b] = ba[b];
      end
   endtask

   // Ticks at ign1/ign2 cycles must be ignored; abort_at returns mid-frame.
   task automatic run_frame(input logic [31:0] bx, input logic [27:0] by, input logic [3:0] ba,
                            input int ign1, input int ign2, input int abort_at);
      out_t got, exp;
      @(negedge CLOCK_50);
      tests++;
      if (current() !== out_t'(0)) begin
         fails++;
         $display("FAIL idle_before_tick: got %h expected %h", current(), out_t'(0));
      end
      bird_x = bx; bird_y = by; bird_alive = ba; frame_tick = 1'b1;
      push_frame(bx, by, ba);
      @(posedge CLOCK_50);
      #1;
      frame_tick = 1'b0;
      bird_x = $urandom; bird_y = 28'($urandom); bird_alive = 4'($urandom);
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge CLOCK_50);
         if (c == abort_at) return;
         got = current();
         obs[c] = got;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: cycle %0d got %h expected an entry", c, got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               fails++;
               $display("FAIL slot_cycle_%0d: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b expected x=%0d y=%0d c=%b plot=%b busy=%b done=%b",
                        c, got.x, got.y, got.c, got.plot, got.busy, got.done,
                        exp.x, exp.y, exp.c, exp.plot, exp.busy, exp.done);
            end
         end
         frame_tick = (c == ign1) || (c == ign2);
      end
      @(posedge CLOCK_50);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; frame_tick = 1'b0; bird_x = '0; bird_y = '0; bird_alive = '0;
      for (int b = 0; b < NB; b++) begin
         m_old_x[b] = 0; m_old_y[b] = 0; m_old_alive[b] = 1'b0;
      end
      #3;
      tests++;
      if (current() !== out_t'(0)) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected %h", current(), out_t'(0));
      end
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b1;
   endtask

   task automatic test_first_frame();
      run_frame({8'd10, 8'd20, 8'd30, 8'd50}, {7'd5, 7'd6, 7'd7, 7'd60}, 4'b0001, 0, 0, 0);
      tests++;
      if (count_plots(1, 52) !== 0) begin
         fails++; $display("FAIL first_erase_quiet: got %0d writes expected 0", count_plots(1, 52));
      end
      tests++;
      if (obs[53] !== {8'd50, 7'd60, 3'b110, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL first_draw_p0: got %h expected x=50 y=60 c=110 plot=1", obs[53]);
      end
      tests++;
      if (obs[54].x !== 8'd50 || obs[54].y !== 7'd61 || obs[54].plot !== 1'b1) begin
         fails++; $display("FAIL first_draw_p1: got %0d,%0d plot=%b expected 50,61 plot=1", obs[54].x, obs[54].y, obs[54].plot);
      end
      tests++;
      if (obs[65].x !== 8'd45 || obs[65].y !== 7'd57 || obs[65].plot !== 1'b1) begin
         fails++; $display("FAIL first_draw_p12: got %0d,%0d plot=%b expected 45,57 plot=1", obs[65].x, obs[65].y, obs[65].plot);
      end
      tests++;
      if (count_plots(66, 104) !== 0) begin
         fails++; $display("FAIL first_dead_quiet: got %0d writes expected 0", count_plots(66, 104));
      end
      tests++;
      if (obs[105].done !== 1'b1 || obs[105].busy !== 1'b0) begin
         fails++; $display("FAIL first_done: got done=%b busy=%b expected done=1 busy=0", obs[105].done, obs[105].busy);
      end
   endtask

   task automatic test_move();
      run_frame({8'd10, 8'd20, 8'd30, 8'd51}, {7'd5, 7'd6, 7'd7, 7'd60}, 4'b0001, 0, 0, 0);
      tests++;
      if (obs[1] !== {8'd50, 7'd60, 3'b000, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL move_erase_p0: got %h expected x=50 y=60 c=000 plot=1", obs[1]);
      end
      tests++;
      if (obs[13] !== {8'd45, 7'd57, 3'b000, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL move_erase_p12: got %h expected x=45 y=57 c=000 plot=1", obs[13]);
      end
      tests++;
      if (count_plots(1, 13) !== 13 || count_plots(14, 52) !== 0) begin
         fails++; $display("FAIL move_erase_count: got %0d/%0d expected 13/0", count_plots(1, 13), count_plots(14, 52));
      end
      tests++;
      if (obs[53].x !== 8'd51 || obs[65].x !== 8'd46 || obs[65].y !== 7'd57) begin
         fails++; $display("FAIL move_draw: got %0d and %0d,%0d expected 51 and 46,57", obs[53].x, obs[65].x, obs[65].y);
      end
   endtask

   task automatic test_clip_low();
      run_frame({8'd10, 8'd20, 8'd30, 8'd2}, {7'd5, 7'd6, 7'd7, 7'd1}, 4'b0001, 0, 0, 0);
      tests++;
      if (count_plots(53, 65) !== 4) begin
         fails++; $display("FAIL clip_low_count: got %0d writes expected 4", count_plots(53, 65));
      end
      tests++;
      if (obs[56] !== {8'd0, 7'd1, 3'b110, 1'b1, 1'b1, 1'b0} || obs[57].plot !== 1'b0) begin
         fails++; $display("FAIL clip_low_edge: got %h / plot=%b expected x=0 y=1 plot=1 / plot=0", obs[56], obs[57].plot);
      end
   endtask

   task automatic test_clip_high();
      run_frame({8'd10, 8'd20, 8'd30, 8'd158}, {7'd5, 7'd6, 7'd7, 7'd118}, 4'b0001, 0, 0, 0);
      tests++;
      if (obs[54] !== {8'd158, 7'd119, 3'b110, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL clip_high_p1: got %h expected x=158 y=119 plot=1", obs[54]);
      end
      tests++;
      if (obs[62] !== {8'd154, 7'd120, 3'b110, 1'b0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL clip_high_p9: got %h expected x=154 y=120 plot=0", obs[62]);
      end
      tests++;
      if (obs[64] !== {8'd153, 7'd121, 3'b110, 1'b0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL clip_high_p11: got %h expected x=153 y=121 plot=0", obs[64]);
      end
   endtask

   task automatic test_ignored_ticks();
      run_frame({8'd90, 8'd80, 8'd70, 8'd60}, {7'd40, 7'd30, 7'd20, 7'd10}, 4'b1111, 30, 105, 0);
      tests++;
      if (count_done() !== 1) begin
         fails++; $display("FAIL ignored_tick_done: got %0d done pulses expected 1", count_done());
      end
   endtask

   task automatic test_back_to_back();
      // starts in the idle cycle right after the previous done
      run_frame({8'd91, 8'd81, 8'd71, 8'd61}, {7'd41, 7'd31, 7'd21, 7'd11}, 4'b1011, 0, 0, 0);
      tests++;
      if (count_plots(27, 39) !== 13 || count_plots(79, 91) !== 0) begin
         fails++; $display("FAIL killed_bird: got erase %0d draw %0d expected 13 and 0", count_plots(27, 39), count_plots(79, 91));
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 5; f++) begin
         logic [31:0] bx;
         logic [27:0] by;
         for (int b = 0; b < NB; b++) begin
            bx[8*b +: 8] = 8'($urandom_range(0, 170));
            by[7*b +: 7] = 7'($urandom_range(0, 125));
         end
         run_frame(bx, by, 4'($urandom), 0, 0, 0);
      end
   endtask

   task automatic test_reset_mid();
      run_frame({8'd100, 8'd110, 8'd120, 8'd130}, {7'd50, 7'd60, 7'd70, 7'd80}, 4'b1111, 0, 0, 70);
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (current() !== out_t'(0)) begin
         fails++; $display("FAIL reset_mid_outputs: got %h expected %h", current(), out_t'(0));
      end
      sb.delete();
      for (int b = 0; b < NB; b++) begin
         m_old_x[b] = 0; m_old_y[b] = 0; m_old_alive[b] = 1'b0;
      end
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b1;
      run_frame({8'd100, 8'd110, 8'd120, 8'd130}, {7'd50, 7'd60, 7'd70, 7'd80}, 4'b1111, 0, 0, 0);
      tests++;
      if (count_plots(1, 52) !== 0 || count_plots(53, 104) === 0) begin
         fails++; $display("FAIL reset_mid_clean: got erase %0d draw %0d expected 0 and nonzero", count_plots(1, 52), count_plots(53, 104));
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_move();
      test_clip_low();
      test_clip_high();
      test_ignored_ticks();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sprite_plot_sequencer.md
Name: sprite_plot_sequencer

Overview:
- Sits directly downstream of the per-bird position logic and directly upstream of vga_adapter (160x120, 3-bit colour).
- On each frame tick it latches every bird's anchor position and alive flag.
- It then streams one pixel per cycle to the adapter: first it erases every bird at last frame's position with the background colour, then it draws every live bird at its new position using the fixed 13-pixel duck shape.
- Off-screen pixels are clipped, so the adapter never receives an out-of-range coordinate with plot asserted.

Parameters:
- NUM_BIRDS, 4, number of bird slots sequenced per frame.
- BIRD_COLOUR, 3'b110, colour used in the draw phase.
- BG_COLOUR, 3'b000, colour used in the erase phase.
- X_MAX, 160, screen width; a pixel is valid when 0 <= x < X_MAX.
- Y_MAX, 120, screen height; a pixel is valid when 0 <= y < Y_MAX.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- frame_tick  in  1  single-cycle start pulse.
- bird_x  in  8*NUM_BIRDS  anchor x per bird; bird i occupies bits [8i+7:8i].
- bird_y  in  7*NUM_BIRDS  anchor y per bird; bird i occupies bits [7i+6:7i].
- bird_alive  in  NUM_BIRDS  1 = draw this bird this frame.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe.
- busy  out  1  high while pixel slots are being issued.
- done  out  1  one-cycle pulse at the end of a frame sequence.

Behaviour:
- Reset: reset is asynchronous, active-low; clock CLOCK_50. Reset asynchronously clears:
  - state to IDLE;
  - all counters;
  - latched new and old positions and alive flags;
  - vga_x, vga_y, vga_colour, vga_plot, busy and done, all to 0.
- Shape table, pixel index p = 0..12, as (dx,dy) offsets from the anchor:
  - (0,0) (0,+1) (-1,0) (-2,0) (-3,0) (-4,0) (-5,0)
  - (-3,+1) (-3,-1) (-4,+2) (-4,-2) (-5,+3) (-5,-3)
- State machine: IDLE -> ERASE -> DRAW -> DONE -> IDLE.
- IDLE:
  - On a clock edge with frame_tick=1, latch bird_x, bird_y and bird_alive into the new registers.
  - Set bird=0, p=0, and go to ERASE.
  - frame_tick is ignored in every other state.
- ERASE:
  - Sweeps bird 0..NUM_BIRDS-1 and, for each bird, p 0..12, one slot per cycle.
  - Uses the old registers; colour is BG_COLOUR.
  - After slot (NUM_BIRDS-1, 12), go to DRAW with bird=0, p=0.
- DRAW:
  - Same sweep using the new registers; colour is BIRD_COLOUR.
  - After the last slot, copy new -> old (positions and alive flags) and go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE.
- Timing:
  - Every slot takes exactly one cycle, regardless of alive or clipping. A frame therefore always takes 26*NUM_BIRDS slot cycles plus 1 DONE cycle.
  - With the edge that accepts the tick called E0, slot s is presented in cycle s+1 after E0.
  - busy=1 exactly in the ERASE and DRAW states (104 cycles for NUM_BIRDS=4).
- Outputs:
  - vga_* are combinational functions of registered state only, with no path from the inputs.
  - They are 0 in IDLE and DONE.
- Arithmetic:
  - px = {1'b0, anchor_x} + sign-extended dx, computed in 9-bit signed.
  - py = {2'b0, anchor_y} + sign-extended dy, computed in 9-bit signed.
  - vga_plot = slot_alive AND 0 <= px < X_MAX AND 0 <= py < Y_MAX.
  - vga_x = px[7:0] and vga_y = py[6:0], driven even when plot=0.
  - There is no modular wrap-around: clipped pixels are dropped, never wrapped.
- First frame after reset: old alive flags are all 0, so every erase slot has plot=0.
- Killed bird (alive goes 1 -> 0): it is erased at its old position and not drawn.
- Reset mid-frame: outputs go to 0 immediately and the sequence is abandoned. Old flags are cleared, so the next frame's erase phase issues no writes. vga_adapter shares the reset and clears the screen itself.
- Overlapping birds: because all erases complete before any draw, an overlapping bird is never partially erased by another bird's erase.

Test Plan (all with NUM_BIRDS=4):
- Reset: assert reset low mid-run -> all outputs 0 within the same cycle; busy=0; a frame_tick after release starts a clean frame.
- First frame, only bird 0 alive at (50,60), tick at E0:
  - cycles 1..52 -> plot=0;
  - cycle 53 -> (50,60) colour 110 plot=1;
  - cycle 54 -> (50,61);
  - cycle 65 -> (45,57);
  - cycles 66..104 -> plot=0;
  - cycle 105 -> done=1, busy=0.
- Move bird 0 to (51,60), next tick:
  - cycles 1..13 -> colour 000 plot=1 at the old shape, (50,60) through (45,57);
  - cycles 53..65 -> new shape, (51,60) through (46,57).
- Clipping with bird 0 at (2,1): of the 13 draw slots, only p=0..3 plot, at (2,1) (2,2) (1,1) (0,1); p=4..12 have plot=0. Total 4 writes.
- Bird 0 at (158,118), alive: p=1 (158,119) plots; p=9 (154,120) has plot=0; p=11 (153,121) has plot=0.
- Tick during busy, and tick in the DONE cycle -> both ignored; no restart; done pulses once. A tick in the following IDLE cycle is accepted.
